// File: rtl/tdc_thermo_decoder.sv
// Delay-line read side: two-flop tap capture, leading-edge hit detect, popcount fine code
// with bubble flag, coarse tagging and a single-entry valid/ready output with lost-hit count.
module tdc_thermo_decoder #(
   parameter int NTAPS    = 64,
   parameter int FINE_W   = 7,
   parameter int COARSE_W = 24,
   parameter int LOST_W   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [NTAPS-1:0]    taps_i,
   output logic                ts_valid,
   input  logic                ts_ready,
   output logic [FINE_W-1:0]   ts_fine,
   output logic [COARSE_W-1:0] ts_coarse,
   output logic                ts_bubble,
   output logic [LOST_W-1:0]   lost_cnt
);

   logic [COARSE_W-1:0] coarse_q, coarse_d;
   logic [NTAPS-1:0]    s1_q, s1_d, s2_q, s2_d;
   logic [COARSE_W-1:0] c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
   logic                prev0_q, prev0_d;
   logic [FINE_W-1:0]   f3_q, f3_d;
   logic                b3_q, b3_d, v3_q, v3_d;
   logic                ts_valid_q, ts_valid_d;
   logic [FINE_W-1:0]   ts_fine_q, ts_fine_d;
   logic [COARSE_W-1:0] ts_coarse_q, ts_coarse_d;
   logic                ts_bubble_q, ts_bubble_d;
   logic [LOST_W-1:0]   lost_q, lost_d;

   logic                hit;
   logic [FINE_W-1:0]   pop_count;
   logic [NTAPS-1:1]    rise_bits;
   logic                bubble;

   // A 0->1 step walking up the line means a bubble; a clean code only ever steps 1->0.
   for (genvar gi = 1; gi < NTAPS; gi++) begin : g_rise
      assign rise_bits[gi] = s2_q[gi] & ~s2_q[gi-1];
   end
   assign bubble = |rise_bits;

   always_comb begin
      pop_count = '0;
      for (int i = 0; i < NTAPS; i++) begin
         pop_count = pop_count + FINE_W'(s2_q[i]);
      end
   end

   assign hit = en & s2_q[0] & ~prev0_q;

   always_comb begin
      coarse_d = en ? coarse_q + COARSE_W'(1) : coarse_q;
      s1_d     = taps_i;
      c1_d     = coarse_q;
      s2_d     = s1_q;
      c2_d     = c1_q;
      prev0_d  = s2_q[0];
      f3_d     = hit ? pop_count : f3_q;
      b3_d     = hit ? bubble    : b3_q;
      c3_d     = hit ? c2_q      : c3_q;
      v3_d     = hit;
   end

   // Output register: a new result may replace the current one only when it is being taken.
   always_comb begin
      ts_valid_d  = ts_valid_q;
      ts_fine_d   = ts_fine_q;
      ts_coarse_d = ts_coarse_q;
      ts_bubble_d = ts_bubble_q;
      lost_d      = lost_q;
      if (v3_q && (!ts_valid_q || ts_ready)) begin
         ts_valid_d  = 1'b1;
         ts_fine_d   = f3_q;
         ts_coarse_d = c3_q;
         ts_bubble_d = b3_q;
      end else if (ts_valid_q && ts_ready) begin
         ts_valid_d = 1'b0;
      end
      if (v3_q && ts_valid_q && !ts_ready && (lost_q != '1)) begin
         lost_d = lost_q + LOST_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         coarse_q    <= '0;
         s1_q        <= '0;
         s2_q        <= '0;
         c1_q        <= '0;
         c2_q        <= '0;
         c3_q        <= '0;
         prev0_q     <= 1'b0;
         f3_q        <= '0;
         b3_q        <= 1'b0;
         v3_q        <= 1'b0;
         ts_valid_q  <= 1'b0;
         ts_fine_q   <= '0;
         ts_coarse_q <= '0;
         ts_bubble_q <= 1'b0;
         lost_q      <= '0;
      end else begin
         coarse_q    <= coarse_d;
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         c1_q        <= c1_d;
         c2_q        <= c2_d;
         c3_q        <= c3_d;
         prev0_q     <= prev0_d;
         f3_q        <= f3_d;
         b3_q        <= b3_d;
         v3_q        <= v3_d;
         ts_valid_q  <= ts_valid_d;
         ts_fine_q   <= ts_fine_d;
         ts_coarse_q <= ts_coarse_d;
         ts_bubble_q <= ts_bubble_d;
         lost_q      <= lost_d;
      end
   end

   assign ts_valid  = ts_valid_q;
   assign ts_fine   = ts_fine_q;
   assign ts_coarse = ts_coarse_q;
   assign ts_bubble = ts_bubble_q;
   assign lost_cnt  = lost_q;

endmodule

// File: tb/tb_tdc_thermo_decoder.sv
// Scenario bench for tdc_thermo_decoder (4-bit coarse counter so wrap is reachable quickly).
module tb_tdc_thermo_decoder;
   localparam int NTAPS = 64, FINE_W = 7, COARSE_W = 4, LOST_W = 8;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                en = 1'b1;
   logic                ts_ready = 1'b1;
   logic [NTAPS-1:0]    taps_i = '0;
   logic                ts_valid, ts_bubble;
   logic [FINE_W-1:0]   ts_fine;
   logic [COARSE_W-1:0] ts_coarse;
   logic [LOST_W-1:0]   lost_cnt;

   typedef struct packed {
      logic [FINE_W-1:0]   fine;
      logic [COARSE_W-1:0] coarse;
      logic                bubble;
   } ts_t;

   ts_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   logic [COARSE_W-1:0] model_coarse;

   tdc_thermo_decoder #(.NTAPS(NTAPS), .FINE_W(FINE_W), .COARSE_W(COARSE_W), .LOST_W(LOST_W)) dut (
      .clk(clk), .rst(rst), .en(en), .taps_i(taps_i),
      .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_fine(ts_fine),
      .ts_coarse(ts_coarse), .ts_bubble(ts_bubble), .lost_cnt(lost_cnt)
   );

   always #5 clk = ~clk;

   // Reference coarse count: value seen at a negedge is the count before the next rising edge.
   always @(posedge clk) begin
      if (rst) model_coarse <= '0;
      else if (en) model_coarse <= model_coarse + 4'd1;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b1; taps_i = '0; ts_ready = 1'b1;
      exp_q.delete();
      cyc(2);
      rst = 1'b0;
   endtask

   function automatic ts_t pop_exp();
      if (exp_q.size() == 0) return '1;
      return exp_q.pop_front();
   endfunction

   function automatic ts_t cur_ts();
      return {ts_fine, ts_coarse, ts_bubble};
   endfunction

   task automatic wait_valid(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         cyc(1);
         if (ts_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      cyc(1);
      checks++;
      if (ts_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid got %b exp 0", ts_valid);
      end
      checks++;
      if ({ts_fine, ts_coarse, ts_bubble, lost_cnt} !== '0) begin
         errors++; $display("FAIL reset_outputs got fine=%0d coarse=%0d bubble=%b lost=%0d exp all 0",
                            ts_fine, ts_coarse, ts_bubble, lost_cnt);
      end
   endtask

   task automatic test_basic();
      ts_t e, g;
      int  n_ts;
      do_reset();
      cyc(10);
      taps_i = 64'h00000000000000FF;
      exp_q.push_back(ts_t'{7'd8, model_coarse, 1'b0});
      cyc(1); taps_i = '1;
      cyc(2);
      checks++;
      if (ts_valid !== 1'b0) begin
         errors++; $display("FAIL basic_early_valid got %b exp 0", ts_valid);
      end
      cyc(1);
      checks++;
      if (ts_valid !== 1'b1) begin
         errors++; $display("FAIL basic_latency got valid=%b exp 1", ts_valid);
      end
      e = pop_exp(); g = cur_ts();
      $display("basic ts fine=%0d coarse=%0d bubble=%b", g.fine, g.coarse, g.bubble);
      checks++;
      if (g !== e) begin
         errors++; $display("FAIL basic_ts got fine=%0d coarse=%0d bubble=%b exp fine=%0d coarse=%0d bubble=%b",
                            g.fine, g.coarse, g.bubble, e.fine, e.coarse, e.bubble);
      end
      n_ts = 0;
      repeat (10) begin
         cyc(1);
         if (ts_valid === 1'b1) n_ts++;
      end
      checks++;
      if (n_ts !== 0) begin
         errors++; $display("FAIL basic_single_ts got %0d extra timestamps exp 0", n_ts);
      end
   endtask

   task automatic test_bubble();
      ts_t e, g;
      bit  ok;
      taps_i = '0; cyc(1);
      taps_i = 64'h00000000000000F7;
      exp_q.push_back(ts_t'{7'd7, model_coarse, 1'b1});
      cyc(1); taps_i = '0;
      wait_valid(8, ok);
      e = pop_exp(); g = cur_ts();
      $display("bubble ts fine=%0d coarse=%0d bubble=%b", g.fine, g.coarse, g.bubble);
      checks++;
      if (!ok || g !== e) begin
         errors++; $display("FAIL bubble_ts got valid=%b fine=%0d coarse=%0d bubble=%b exp fine=%0d coarse=%0d bubble=%b",
                            ok, g.fine, g.coarse, g.bubble, e.fine, e.coarse, e.bubble);
      end
      cyc(1);
   endtask

   task automatic test_backpressure();
      ts_t e, g;
      do_reset();
      ts_ready = 1'b0;
      cyc(3);
      taps_i = 64'h000000000000000F;
      exp_q.push_back(ts_t'{7'd4, model_coarse, 1'b0});
      cyc(1); taps_i = '0; cyc(3);
      taps_i = 64'h000000000000003F;
      cyc(1); taps_i = '0; cyc(3);
      taps_i = 64'h0000000000000001;
      cyc(1); taps_i = '0;
      e = exp_q[0];
      repeat (8) begin
         cyc(1);
         g = cur_ts();
         checks++;
         if (ts_valid !== 1'b1 || g !== e) begin
            errors++; $display("FAIL bp_hold got valid=%b fine=%0d coarse=%0d bubble=%b exp valid=1 fine=%0d coarse=%0d bubble=%b",
                               ts_valid, g.fine, g.coarse, g.bubble, e.fine, e.coarse, e.bubble);
         end
      end
      checks++;
      if (lost_cnt !== 8'd2) begin
         errors++; $display("FAIL bp_lost got %0d exp 2", lost_cnt);
      end
      ts_ready = 1'b1;
      e = pop_exp(); g = cur_ts();
      $display("backpressure ts fine=%0d coarse=%0d bubble=%b", g.fine, g.coarse, g.bubble);
      checks++;
      if (ts_valid !== 1'b1 || g !== e) begin
         errors++; $display("FAIL bp_transfer got valid=%b fine=%0d exp valid=1 fine=%0d", ts_valid, g.fine, e.fine);
      end
      cyc(1);
      checks++;
      if (ts_valid !== 1'b0) begin
         errors++; $display("FAIL bp_drop got valid=%b exp 0", ts_valid);
      end
      cyc(3);
      checks++;
      if (ts_valid !== 1'b0 || lost_cnt !== 8'd2) begin
         errors++; $display("FAIL bp_after got valid=%b lost=%0d exp valid=0 lost=2", ts_valid, lost_cnt);
      end
   endtask

   task automatic test_back_to_back();
      ts_t e, g;
      do_reset();
      ts_ready = 1'b0;
      cyc(2);
      taps_i = 64'h0000000000000003;
      exp_q.push_back(ts_t'{7'd2, model_coarse, 1'b0});
      cyc(1); taps_i = '0; cyc(3);
      taps_i = 64'h00000000000007FF;
      exp_q.push_back(ts_t'{7'd11, model_coarse, 1'b0});
      cyc(1); taps_i = '0; cyc(2);
      ts_ready = 1'b1;
      e = pop_exp(); g = cur_ts();
      $display("b2b first ts fine=%0d coarse=%0d bubble=%b", g.fine, g.coarse, g.bubble);
      checks++;
      if (ts_valid !== 1'b1 || g !== e) begin
         errors++; $display("FAIL b2b_first got valid=%b fine=%0d coarse=%0d exp valid=1 fine=%0d coarse=%0d",
                            ts_valid, g.fine, g.coarse, e.fine, e.coarse);
      end
      cyc(1);
      e = pop_exp(); g = cur_ts();
      $display("b2b second ts fine=%0d coarse=%0d bubble=%b", g.fine, g.coarse, g.bubble);
      checks++;
      if (ts_valid !== 1'b1 || g !== e) begin
         errors++; $display("FAIL b2b_second got valid=%b fine=%0d coarse=%0d exp valid=1 fine=%0d coarse=%0d",
                            ts_valid, g.fine, g.coarse, e.fine, e.coarse);
      end
      checks++;
      if (lost_cnt !== 8'd0) begin
         errors++; $display("FAIL b2b_lost got %0d exp 0", lost_cnt);
      end
      cyc(1);
      checks++;
      if (ts_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_drop got valid=%b exp 0", ts_valid);
      end
   endtask

   task automatic test_coarse_wrap();
      ts_t e, g;
      bit  ok;
      int  guard;
      do_reset();
      guard = 0;
      while (model_coarse != 4'd15 && guard < 20) begin
         cyc(1); guard++;
      end
      taps_i = 64'h000000000000FFFF;
      exp_q.push_back(ts_t'{7'd16, 4'd15, 1'b0});
      cyc(1); taps_i = '0; cyc(3);
      taps_i = 64'h0000000000000007;
      exp_q.push_back(ts_t'{7'd3, 4'd3, 1'b0});
      e = pop_exp(); g = cur_ts();
      $display("wrap ts fine=%0d coarse=%0d bubble=%b", g.fine, g.coarse, g.bubble);
      checks++;
      if (ts_valid !== 1'b1 || g !== e) begin
         errors++; $display("FAIL wrap_at_15 got valid=%b fine=%0d coarse=%0d exp valid=1 fine=%0d coarse=%0d",
                            ts_valid, g.fine, g.coarse, e.fine, e.coarse);
      end
      cyc(1); taps_i = '0;
      wait_valid(8, ok);
      e = pop_exp(); g = cur_ts();
      $display("wrap ts fine=%0d coarse=%0d bubble=%b", g.fine, g.coarse, g.bubble);
      checks++;
      if (!ok || g !== e) begin
         errors++; $display("FAIL wrap_after got valid=%b fine=%0d coarse=%0d exp fine=%0d coarse=%0d",
                            ok, g.fine, g.coarse, e.fine, e.coarse);
      end
      cyc(1);
   endtask

   task automatic test_reset_mid();
      ts_t e, g;
      bit  ok;
      int  n_ts;
      do_reset();
      ts_ready = 1'b0;
      cyc(2);
      taps_i = 64'h0000000000000001;
      cyc(1); taps_i = '0; cyc(3);
      taps_i = 64'h0000000000000003;
      cyc(1); taps_i = '0; cyc(3);
      checks++;
      if (ts_valid !== 1'b1 || lost_cnt !== 8'd1) begin
         errors++; $display("FAIL rstmid_pre got valid=%b lost=%0d exp valid=1 lost=1", ts_valid, lost_cnt);
      end
      taps_i = 64'h000000000000000F;
      cyc(1); taps_i = '0; rst = 1'b1;
      cyc(1); rst = 1'b0;
      exp_q.delete();
      repeat (8) begin
         cyc(1);
         checks++;
         if ({ts_valid, ts_fine, ts_coarse, ts_bubble, lost_cnt} !== '0) begin
            errors++; $display("FAIL rstmid_zero got valid=%b fine=%0d coarse=%0d bubble=%b lost=%0d exp all 0",
                               ts_valid, ts_fine, ts_coarse, ts_bubble, lost_cnt);
         end
      end
      ts_ready = 1'b1;
      en = 1'b0; taps_i = '1;
      n_ts = 0;
      repeat (10) begin
         cyc(1);
         if (ts_valid === 1'b1) n_ts++;
      end
      checks++;
      if (n_ts !== 0) begin
         errors++; $display("FAIL en_low_ts got %0d timestamps exp 0", n_ts);
      end
      taps_i = '0; en = 1'b1;
      cyc(3);
      taps_i = 64'h000000000000001F;
      exp_q.push_back(ts_t'{7'd5, model_coarse, 1'b0});
      cyc(1); taps_i = '0;
      wait_valid(8, ok);
      e = pop_exp(); g = cur_ts();
      $display("en hold ts fine=%0d coarse=%0d bubble=%b", g.fine, g.coarse, g.bubble);
      checks++;
      if (!ok || g !== e) begin
         errors++; $display("FAIL en_hold_coarse got valid=%b fine=%0d coarse=%0d exp fine=%0d coarse=%0d",
                            ok, g.fine, g.coarse, e.fine, e.coarse);
      end
      cyc(1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_bubble();
      test_backpressure();
      test_back_to_back();
      test_coarse_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
